sbox_pe_sequencer: RTL and testbench
====================================

// Module: sbox_pe_sequencer
// PURPOSE
// Sequences one 4-bit PRESENT S-box built from dual-rail BDD pass-transistor slices with a
// precharge stage: precharge phase, then evaluate phase, then capture and rail check.
// Takes nibble requests over valid/ready. Drives the slice select rails, the 'pre' line and
// the constant INPUT0/INPUT1 rails. Returns the captured uncomplemented output with an error flag.
// Sits between the round datapath and the transistor-level S-box instance.
// PARAMETERS
// PRE_CYCLES   2   cycles 'pre' held low before evaluate (>=1)
// EVAL_CYCLES  3   cycles 'pre' held high with rails driven before capture (>=1)
// PORTS
// clk         in   1  single clock, rising edge
// rst_n       in   1  asynchronous, active-low reset
// in_valid    in   1  request valid
// in_ready    out  1  request accepted when in_valid & in_ready
// in_data     in   4  S-box input nibble (bit i -> slice select variable v_i)
// select      out  4  true select rails to S-box (select_v3..v0)
// select_bar  out  4  complement select rails to S-box
// pre         out  1  0 = precharge, 1 = evaluate
// rail0       out  1  drives S-box INPUT0 (constant-0 leaf)
// rail1       out  1  drives S-box INPUT1 (constant-1 leaf)
// u_out       in   4  uncomplemented S-box outputs (post precharge inverter)
// c_out       in   4  complemented S-box outputs
// out_valid   out  1  result valid; held until out_ready
// out_ready   in   1  consumer accepts result
// out_data    out  4  captured u_out
// out_err     out  1  dual-rail or precharge check failed for this result
// err_cnt     out  8  saturating count of results with out_err=1
// BEHAVIOUR
// - FSM states: IDLE, PRE, EVAL, DONE. All outputs are registered.
// - Async reset: state=IDLE, in_ready=0 until first clk edge after release, select=0,
//   select_bar=0, pre=0, rail0=0, rail1=0, out_valid=0, out_data=0, out_err=0, err_cnt=0.
// - Reset mid-operation: the result is discarded and no out_valid is produced; all rails go
//   to the reset values at once.
// - IDLE: in_ready=1, pre=0, select=select_bar=0. On accept, latch in_data, load counter
//   with PRE_CYCLES-1, go to PRE.
// - PRE: pre=0, select=select_bar=0, rail0=0, rail1=0.
//   - Counter 0 -> sample precharge check: fail if u_out!=0 or c_out!=0.
//   - Then go to EVAL with counter=EVAL_CYCLES-1.
// - EVAL: pre=1, select=latched nibble, select_bar=~nibble, rail0=0, rail1=1.
//   - All three rails change on the same edge from the 0/0 break state.
//   - select & select_bar are never both 1, in any state.
// - EVAL, counter 0: capture out_data=u_out.
//   - Rail error if any bit has u_out[i]==c_out[i].
//   - out_err = rail error | precharge error.
//   - err_cnt += out_err, saturating at 255.
//   - Go to DONE; out_valid=1 from the next cycle.
// - DONE: pre=0, select=select_bar=0, rail1=0 (recharge starts); in_ready=0.
//   - out_valid, out_data and out_err are stable until out_ready=1. Then out_valid=0 and
//     state goes to IDLE.
// - Latency: accept at edge T -> out_valid high after edge T+PRE_CYCLES+EVAL_CYCLES.
//   Minimum issue interval is PRE_CYCLES+EVAL_CYCLES+2 cycles.
// - in_valid while not IDLE is ignored (in_ready=0). out_ready outside DONE is ignored.
// - Counters are wide enough for the parameter maxima; there is no wrap inside a phase.
// TESTING
// - Model: S-box behavioural model with S=C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
//   - pre=1 and rails valid: u=S[select], c=~u.
//   - Otherwise: u=c=0.
// - Reset, then send in_data=0x0 with out_ready=1 -> out_data=0xC, out_err=0.
//   out_valid rises exactly 5 cycles after accept (defaults).
// - Sweep in_data 0x0..0xF back-to-back -> each out_data matches S; err_cnt stays 0.
//   Accepts are spaced 7 cycles apart.
// - Hold out_ready=0 for 10 cycles after in_data=0x5 -> out_valid and out_data=0x0 held.
//   in_ready=0 throughout; release -> IDLE next cycle.
// - Force c_out bit2 = u_out bit2 during EVAL for in_data=0xA -> out_data=0xF, out_err=1,
//   err_cnt=1. 300 forced errors -> err_cnt=255.
// - Force u_out=0x1 during PRE -> out_err=1 even with correct evaluate.
// - Assert rst_n=0 in the middle of EVAL -> pre, select and select_bar go to 0 immediately.
//   No out_valid follows; the next request completes normally.
// - Every cycle, assert (select & select_bar)==0 and pre==0 whenever select|select_bar==0.

Source files
------------

// File: rtl/sbox_pe_sequencer.sv
// Sequencer for a dual-rail BDD pass-transistor PRESENT S-box: precharge, evaluate, capture.
// Checks the precharge state and the dual-rail outputs of every result and flags failures.
module sbox_pe_sequencer #(
    parameter int unsigned PRE_CYCLES  = 2,
    parameter int unsigned EVAL_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic [3:0] select,
    output logic [3:0] select_bar,
    output logic       pre,
    output logic       rail0,
    output logic       rail1,
    input  logic [3:0] u_out,
    input  logic [3:0] c_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       out_err,
    output logic [7:0] err_cnt
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StPre  = 2'd1;
    localparam logic [1:0] StEval = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam int unsigned MaxCycles = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      nib_q, nib_d;
    logic            pre_err_q, pre_err_d;
    logic            in_ready_q, in_ready_d;
    logic [3:0]      select_q, select_d;
    logic [3:0]      select_bar_q, select_bar_d;
    logic            pre_q, pre_d;
    logic            rail0_q, rail0_d;
    logic            rail1_q, rail1_d;
    logic            out_valid_q, out_valid_d;
    logic [3:0]      out_data_q, out_data_d;
    logic            out_err_q, out_err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            rail_err;

    // A rail pair with equal values means the dual-rail network did not resolve.
    assign rail_err = |(~(u_out ^ c_out));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        nib_d        = nib_q;
        pre_err_d    = pre_err_q;
        in_ready_d   = in_ready_q;
        select_d     = select_q;
        select_bar_d = select_bar_q;
        pre_d        = pre_q;
        rail0_d      = 1'b0;
        rail1_d      = rail1_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_err_d    = out_err_q;
        err_cnt_d    = err_cnt_q;

        case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    state_d    = StPre;
                    nib_d      = in_data;
                    cnt_d      = CntW'(PRE_CYCLES - 1);
                    in_ready_d = 1'b0;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            StPre: begin
                if (cnt_q == '0) begin
                    pre_err_d    = (|u_out) | (|c_out);
                    state_d      = StEval;
                    cnt_d        = CntW'(EVAL_CYCLES - 1);
                    pre_d        = 1'b1;
                    select_d     = nib_q;
                    select_bar_d = ~nib_q;
                    rail1_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StEval: begin
                if (cnt_q == '0) begin
                    out_data_d   = u_out;
                    out_err_d    = rail_err | pre_err_q;
                    if ((rail_err | pre_err_q) && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    out_valid_d  = 1'b1;
                    state_d      = StDone;
                    pre_d        = 1'b0;
                    select_d     = 4'h0;
                    select_bar_d = 4'h0;
                    rail1_d      = 1'b0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                    in_ready_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            nib_q        <= 4'h0;
            pre_err_q    <= 1'b0;
            in_ready_q   <= 1'b0;
            select_q     <= 4'h0;
            select_bar_q <= 4'h0;
            pre_q        <= 1'b0;
            rail0_q      <= 1'b0;
            rail1_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 4'h0;
            out_err_q    <= 1'b0;
            err_cnt_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nib_q        <= nib_d;
            pre_err_q    <= pre_err_d;
            in_ready_q   <= in_ready_d;
            select_q     <= select_d;
            select_bar_q <= select_bar_d;
            pre_q        <= pre_d;
            rail0_q      <= rail0_d;
            rail1_q      <= rail1_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_err_q    <= out_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign select     = select_q;
    assign select_bar = select_bar_q;
    assign pre        = pre_q;
    assign rail0      = rail0_q;
    assign rail1      = rail1_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_sbox_pe_sequencer.sv
// Directed bench for sbox_pe_sequencer with a behavioural dual-rail S-box model.
// Fault hooks corrupt the model's rails to exercise the precharge and rail checks.
module tb_sbox_pe_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] select;
    logic [3:0] select_bar;
    logic       pre;
    logic       rail0;
    logic       rail1;
    logic [3:0] u_out;
    logic [3:0] c_out;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_err;
    logic [7:0] err_cnt;

    logic       force_c2;
    logic       force_pre_u;
    int         n_vec;
    int         n_err;
    int         cyc;

    logic [3:0] sbox [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    sbox_pe_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .select     (select),
        .select_bar (select_bar),
        .pre        (pre),
        .rail0      (rail0),
        .rail1      (rail1),
        .u_out      (u_out),
        .c_out      (c_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        u_out = 4'h0;
        c_out = 4'h0;
        if (pre && rail1 && !rail0 && ((select ^ select_bar) == 4'hF)) begin
            u_out = sbox[select];
            c_out = ~sbox[select];
        end
        if (force_c2 && pre) c_out[2] = u_out[2];
        if (force_pre_u && !pre) u_out = 4'h1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Rail invariants, sampled away from the active edge.
    always @(negedge clk) begin
        check_eq("sel_overlap", {28'h0, select & select_bar}, 32'h0);
        check_eq("pre_without_sel", {31'h0, pre && ((select | select_bar) == 4'h0)}, 32'h0);
    end

    task automatic accept(input logic [3:0] nib, output int acc_cyc);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check_eq("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_data  = nib;
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check_eq("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_txn(input logic [3:0] nib, output int acc_cyc, output int lat);
        accept(nib, acc_cyc);
        wait_valid(lat);
    endtask

    initial begin
        int acc;
        int prev_acc;
        int lat;
        logic seen;
        n_vec       = 0;
        n_err       = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 4'h0;
        out_ready   = 1'b1;
        force_c2    = 1'b0;
        force_pre_u = 1'b0;

        // Reset state
        #12;
        check_eq("rst_in_ready", {31'h0, in_ready}, 32'd0);
        check_eq("rst_outs", {20'h0, select, select_bar, pre, rail0, rail1, out_valid},
                 32'h0);
        check_eq("rst_data", {19'h0, out_data, out_err, err_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("in_ready_before_edge", {31'h0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check_eq("in_ready_after_edge", {31'h0, in_ready}, 32'd1);

        // First request and latency
        run_txn(4'h0, acc, lat);
        check_eq("first_latency", lat, 32'd5);
        check_eq("first_data", {28'h0, out_data}, 32'hC);
        check_eq("first_err", {31'h0, out_err}, 32'd0);
        @(posedge clk); #1;
        check_eq("first_valid_drop", {31'h0, out_valid}, 32'd0);

        // Back-to-back sweep
        prev_acc = 0;
        for (int i = 0; i < 16; i++) begin
            run_txn(4'(i), acc, lat);
            check_eq($sformatf("sweep_data_%0d", i), {28'h0, out_data}, {28'h0, sbox[i]});
            check_eq($sformatf("sweep_err_%0d", i), {31'h0, out_err}, 32'd0);
            check_eq($sformatf("sweep_cnt_%0d", i), {24'h0, err_cnt}, 32'd0);
            if (i > 0) check_eq($sformatf("sweep_spacing_%0d", i), acc - prev_acc, 32'd7);
            prev_acc = acc;
            @(posedge clk); #1;
        end

        // Backpressure hold
        out_ready = 1'b0;
        run_txn(4'h5, acc, lat);
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("hold_valid_%0d", i), {31'h0, out_valid}, 32'd1);
            check_eq($sformatf("hold_data_%0d", i), {28'h0, out_data}, 32'h0);
            check_eq($sformatf("hold_ready_%0d", i), {31'h0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("hold_release_valid", {31'h0, out_valid}, 32'd0);
        check_eq("hold_release_ready", {31'h0, in_ready}, 32'd1);

        // Rail error on bit 2
        force_c2 = 1'b1;
        run_txn(4'hA, acc, lat);
        check_eq("rail_err_data", {28'h0, out_data}, 32'hF);
        check_eq("rail_err_flag", {31'h0, out_err}, 32'd1);
        check_eq("rail_err_cnt", {24'h0, err_cnt}, 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 300; i++) begin
            run_txn(4'hA, acc, lat);
            @(posedge clk); #1;
        end
        force_c2 = 1'b0;
        check_eq("err_cnt_saturated", {24'h0, err_cnt}, 32'd255);

        // Precharge error with a clean evaluate
        force_pre_u = 1'b1;
        run_txn(4'h3, acc, lat);
        check_eq("pre_err_data", {28'h0, out_data}, 32'hB);
        check_eq("pre_err_flag", {31'h0, out_err}, 32'd1);
        check_eq("pre_err_cnt", {24'h0, err_cnt}, 32'd255);
        force_pre_u = 1'b0;
        @(posedge clk); #1;

        // Reset during evaluate
        accept(4'h7, acc);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_eq("mid_eval_pre", {31'h0, pre}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rails", {23'h0, pre, select, select_bar}, 32'h0);
        check_eq("mid_rst_rail1", {31'h0, rail1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check_eq("no_valid_after_rst", {31'h0, seen}, 32'd0);
        run_txn(4'h9, acc, lat);
        check_eq("post_rst_latency", lat, 32'd5);
        check_eq("post_rst_data", {28'h0, out_data}, 32'hE);
        check_eq("post_rst_err", {31'h0, out_err}, 32'd0);
        check_eq("post_rst_cnt", {24'h0, err_cnt}, 32'd0);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
